// File: rtl/mod_p_pkg.sv
// Shared constants and types for the mod-p reducer (p = 2^255 - 19).
package mod_p_pkg;

  // Operand width this block is built for.
  localparam int N_DEF = 256;

  // Width of the bit counter that walks the N operand bits.
  localparam int CNT_W = $clog2(N_DEF);

  // Curve25519 field prime, 2^255 - 19.
  localparam logic [N_DEF-1:0] P = (256'd1 << 255) - 256'd19;

  // Reduction sequence: capture the operand, run N division steps, present the result.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_p_csub.sv
// One restoring-division step: compare the (N+1)-bit partial remainder with P
// and subtract P when it fits. The result is always below P, so it fits in N bits.
module mod_p_csub
  import mod_p_pkg::*;
#(
  parameter int N = 256
) (
  input  logic [N:0]   t,
  output logic [N-1:0] r_next
);

  localparam logic [N-1:0] P_N = P[N-1:0];

  logic          ge;
  logic [N-1:0]  diff_lo;

  // Conditional subtract. The low N bits of (t - P) depend only on the low N
  // bits of t, and the subtract is only taken when t >= P, so the carry out of
  // bit N-1 is never needed.
  always_comb begin
    ge      = (t >= {1'b0, P_N});
    diff_lo = t[N-1:0] - P_N;
    r_next  = ge ? diff_lo : t[N-1:0];
  end

endmodule

// File: rtl/mod_p.sv
// Bit-serial reduction of an N-bit unsigned operand modulo p = 2^255 - 19.
// Restoring long division that keeps only the remainder, one operand bit per
// clock, MSB first. The result appears 258 edges after reset is released and
// is held until the next reset.
//
// Handshake: there is no valid/ready pair. A reduction starts on the first
// rising edge with rst low (n is captured there and ignored afterwards);
// done rises together with the final rem and both stay frozen until rst is
// asserted again. Before done, rem reads 0 and never shows partial results.
//
// The FSM register is the signal 'state'; it is left as a named internal
// signal so checkers can bind to it without widening the port list.
module mod_p
  import mod_p_pkg::*;
#(
  parameter int N = 256
) (
  input  logic [N-1:0] n,
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] rem,
  output logic         done
);

  state_t             state;
  state_t             state_next;

  logic [N-1:0]       q;       // operand shift register, MSB consumed first
  logic [N-1:0]       r;       // working remainder, always < P
  logic [N-1:0]       r_red;   // r after one division step
  logic [CNT_W-1:0]   cnt;     // index of the operand bit being consumed
  logic [N:0]         t;       // partial remainder with next bit appended

  // Bring down the next operand bit; r < 2^255 so t < 2^256 fits N+1 bits.
  assign t = {r, q[N-1]};

  mod_p_csub #(
    .N (N)
  ) u_csub (
    .t      (t),
    .r_next (r_red)
  );

  // FSM state register; reset returns to LOAD so the next free edge restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one LOAD edge, N CALC edges, then park in DONE.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: state_next = CALC;
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Datapath: operand capture, division steps, and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      r    <= '0;
      cnt  <= '0;
      rem  <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          q   <= n;
          r   <= '0;
          cnt <= CNT_W'(N - 1);
        end
        CALC: begin
          r   <= r_red;
          q   <= {q[N-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          // r is stable here, so repeated writes keep rem unchanged.
          rem  <= r;
          done <= 1'b1;
        end
        default: begin
          q   <= '0;
          r   <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_p.sv
// Bench for mod_p: directed boundary operands plus random operands, with a
// scoreboard queue filled by the driver and drained by an independent monitor.
module tb_mod_p;

  localparam int W   = 256;
  localparam int LAT = 258;  // edges from reset release to done
  localparam int NUM_RANDOM = 180;

  // Reference prime, built independently of the design package.
  localparam logic [W-1:0] P_REF = (256'd1 << 255) - 256'd19;

  logic [W-1:0] n;
  logic         clk;
  logic         rst;
  logic [W-1:0] rem;
  logic         done;

  int tests;
  int fails;

  logic [W-1:0] exp_q[$];

  mod_p #(
    .N (W)
  ) dut (
    .n    (n),
    .clk  (clk),
    .rst  (rst),
    .rem  (rem),
    .done (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    n   = '0;
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] v);
    return v % P_REF;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) begin
      v = {v[W-33:0], 32'($urandom)};
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse reset for one edge with the operand applied, then run a full
  // reduction. With scramble set, n is changed every cycle after the LOAD edge.
  task automatic reduce(input logic [W-1:0] val, input logic [W-1:0] expected,
                        input bit scramble);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n   = val;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(expected);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk);
      #1;
      if (scramble) n = rand_op();
    end
    check("done_early", {255'd0, done}, 256'd0);
    @(posedge clk);
    #1;
    check("done_latency", {255'd0, done}, 256'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (scramble) n = rand_op();
    end
  endtask

  // Start a reduction and abort it with reset partway through.
  task automatic aborted_run(input logic [W-1:0] val, input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n   = val;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_done;
  logic [W-1:0] held;

  initial begin
    prev_done = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {255'd0, done}, 256'd0);
        end else begin
          held = exp_q.pop_front();
          check("rem_result", rem, held);
        end
      end else if (done) begin
        check("rem_hold", rem, held);
      end else begin
        check("rem_hidden", rem, 256'd0);
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] v;
  logic [W-1:0] dead;
  logic [W-1:0] dead_exp;

  initial begin
    tests = 0;
    fails = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rem", rem, 256'd0);
    check("reset_done", {255'd0, done}, 256'd0);

    // Directed boundaries with known answers.
    reduce(256'd7000000, 256'd7000000, 1'b0);
    reduce({W{1'b1}}, 256'd37, 1'b0);
    dead     = {8{32'hDEADBEEF}};
    dead_exp = {32'h5EADBEEF, {6{32'hDEADBEEF}}, 32'hDEADBF02};
    reduce(dead, dead_exp, 1'b0);
    reduce(P_REF, 256'd0, 1'b0);
    reduce(P_REF - 256'd1, P_REF - 256'd1, 1'b0);
    reduce(256'd0, 256'd0, 1'b0);
    reduce(P_REF + 256'd1, 256'd1, 1'b1);

    // Abort a reduction of all-ones and restart with 5.
    aborted_run({W{1'b1}}, 100);
    reduce(256'd5, 256'd5, 1'b0);

    // Random operands, with n disturbed during CALC/DONE on every other run.
    for (int k = 0; k < NUM_RANDOM; k++) begin
      v = rand_op();
      if (k % 4 == 1) v[W-1] = 1'b1;
      reduce(v, ref_mod(v), (k % 2) == 1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 256'(exp_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #(10 * 80000);
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
